// File: rtl/fsmc_reg_bank_if.sv
// fsmc_reg_bank_if - bus-side signal bundle between the FSMC bridge and
// the user register bank.
//   en       chip select (level), driven by the bridge
//   state    access direction, 1 = read, 0 = write
//   addr     register index, valid while en = 1
//   wr_data  write data
//   rd_data  registered read data from the bank
//   rd_valid one-cycle pulse when rd_data is updated
//   err      one-cycle pulse on an illegal access
// master = bridge side, slave = register bank side.
interface fsmc_reg_bank_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3
) ();
    logic              en;
    logic              state;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              err;

    modport master (
        output en, state, addr, wr_data,
        input  rd_data, rd_valid, err
    );

    modport slave (
        input  en, state, addr, wr_data,
        output rd_data, rd_valid, err
    );
endinterface

// File: rtl/fsmc_reg_bank.sv
// fsmc_reg_bank - parametrised register bank on the user side of the FSMC
// bridge. One access is taken per rising edge of bus.en; registers are
// bus read/write or hardware-driven read-only (RO_MASK).
// Ports:
//   clk      fabric clock
//   reset_n  asynchronous active-low reset
//   bus      fsmc_reg_bank_if.slave (en/state/addr/wr_data in,
//            rd_data/rd_valid/err out)
//   wr_pulse per-register one-cycle write strobe (cycle after the write)
//   reg_q    flattened register contents, reg i at [i*DATA_W +: DATA_W]
//   hw_din   hardware load data, same packing as reg_q
//   hw_we    per-register hardware load enable
// Optional: define FSMC_REG_RC_EN to make read-only registers read-to-clear.
module fsmc_reg_bank #(
    parameter int unsigned         DATA_W   = 16,
    parameter int unsigned         NUM_REGS = 8,
    parameter int unsigned         ADDR_W   = 3,
    parameter logic [NUM_REGS-1:0] RO_MASK  = 8'hC0,
    parameter logic [DATA_W-1:0]   RST_VAL  = '0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    fsmc_reg_bank_if.slave               bus,
    output logic [NUM_REGS-1:0]          wr_pulse,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q,
    input  logic [NUM_REGS*DATA_W-1:0]   hw_din,
    input  logic [NUM_REGS-1:0]          hw_we
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic                en_d;
    logic                access;
    logic [NUM_REGS-1:0] sel;
    logic [DATA_W-1:0]   sel_data;
    logic                addr_ok;
    logic                sel_ro;
    logic                bus_wr;
    logic                wr_bad;
    logic                rd;
    logic                rd_bad;

    logic [DATA_W-1:0]   rd_data_q;
    logic                rd_valid_q;
    logic                err_q;

    // Address decode; sel stays zero for an out-of-range index, which also
    // forces sel_data to zero for such reads.
    always_comb begin
        access   = bus.en & ~en_d;
        sel      = '0;
        sel_data = '0;
        addr_ok  = 1'b0;
        sel_ro   = 1'b0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (32'(bus.addr) == i) begin
                sel[i]   = 1'b1;
                sel_data = regs[i];
                addr_ok  = 1'b1;
                sel_ro   = RO_MASK[i];
            end
        end
        bus_wr = access & ~bus.state & addr_ok & ~sel_ro;
        wr_bad = access & ~bus.state & ~(addr_ok & ~sel_ro);
        rd     = access & bus.state;
        rd_bad = rd & ~addr_ok;
    end

    // Register storage: bus write beats hardware load, hardware load beats
    // read-to-clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RST_VAL;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (bus_wr && sel[i]) begin
                    regs[i] <= bus.wr_data;
                end else if (hw_we[i]) begin
                    regs[i] <= hw_din[i*DATA_W +: DATA_W];
                end
`ifdef FSMC_REG_RC_EN
                else if (rd && sel[i] && RO_MASK[i]) begin
                    regs[i] <= '0;
                end
`endif
            end
        end
    end

    // en_d resets high so an en already asserted at reset release is not
    // mistaken for a new access.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_d       <= 1'b1;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            wr_pulse   <= '0;
            err_q      <= 1'b0;
        end else begin
            en_d       <= bus.en;
            rd_valid_q <= rd;
            wr_pulse   <= bus_wr ? sel : '0;
            err_q      <= wr_bad | rd_bad;
            if (rd) begin
                rd_data_q <= sel_data;
            end
        end
    end

    always_comb begin
        reg_q = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            reg_q[i*DATA_W +: DATA_W] = regs[i];
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.err      = err_q;

endmodule
